// File: rtl/mc_main_ctrl_pkg.sv
// Shared definitions for the multicycle main controller: opcodes, state
// encodings, datapath select encodings and the control-strobe bundle.
package mc_main_ctrl_pkg;

  localparam int OPCODE_W = 6;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Controller states; codes 13..15 are unused and recover to IDLE
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Complete set of datapath strobes driven by the controller
  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence
  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_legal = 1'b1;
      default:                                   opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-strobe decoder for mc_main_ctrl. Strobes are a pure
// function of the state, except the FETCH load enables (gated by mem_ready),
// the branch PC enable (gated by zero) and the DECODE illegal flag.
module mc_out_decode
  import mc_main_ctrl_pkg::*;
(
  input  state_t     st,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Decode the current state into the datapath strobe bundle
  always_comb begin
    ctrl = '0;
    case (st)
      S_IDLE: begin
        ctrl = '0;
      end
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        // branch target is precomputed here while the opcode is decoded
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALU_ADD;
        ctrl.illegal   = ~opcode_legal(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main control FSM for the register-file/ALU/data-memory datapath.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN;
// without it instr_cnt is tied to zero and no counter flops exist.
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_en,
  output logic [1:0]     pc_src,
  output logic           i_or_d,
  output logic           ir_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           illegal,
  output logic [STW-1:0] state,
  output logic [31:0]    instr_cnt
);

  state_t state_r;
  state_t state_nxt_s;
  state_t after_retire_s;
  ctrl_t  ctrl_s;

  // run is only consulted when an instruction finishes (or from IDLE)
  assign after_retire_s = run ? S_FETCH : S_IDLE;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   state_nxt_s = after_retire_s;
      S_FETCH:  state_nxt_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_R:         state_nxt_s = S_EXEC;
          OP_BEQ:       state_nxt_s = S_BRANCH;
          OP_J:         state_nxt_s = S_JUMP;
          OP_ADDI:      state_nxt_s = S_ADDIEX;
          default:      state_nxt_s = after_retire_s;
        endcase
      end
      S_MEMADR: state_nxt_s = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_nxt_s = after_retire_s;
      S_MEMWR:  state_nxt_s = mem_ready ? after_retire_s : S_MEMWR;
      S_EXEC:   state_nxt_s = S_RWB;
      S_RWB:    state_nxt_s = after_retire_s;
      S_BRANCH: state_nxt_s = after_retire_s;
      S_JUMP:   state_nxt_s = after_retire_s;
      S_ADDIEX: state_nxt_s = S_ADDIWB;
      S_ADDIWB: state_nxt_s = after_retire_s;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  mc_out_decode u_out_decode (
    .st        (state_r),
    .opcode    (opcode[OPCODE_W-1:0]),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  assign pc_en      = ctrl_s.pc_en;
  assign pc_src     = ctrl_s.pc_src;
  assign i_or_d     = ctrl_s.i_or_d;
  assign ir_write   = ctrl_s.ir_write;
  assign mem_read   = ctrl_s.mem_read;
  assign mem_write  = ctrl_s.mem_write;
  assign mem_to_reg = ctrl_s.mem_to_reg;
  assign reg_dst    = ctrl_s.reg_dst;
  assign reg_write  = ctrl_s.reg_write;
  assign alu_src_a  = ctrl_s.alu_src_a;
  assign alu_src_b  = ctrl_s.alu_src_b;
  assign alu_op     = ctrl_s.alu_op;
  assign illegal    = ctrl_s.illegal;
  assign state      = STW'(state_r);

`ifdef CTRL_PERF_CNT_EN
  logic        retire_s;
  logic [31:0] instr_cnt_r;

  // Final cycle of every legal instruction; illegal opcodes never get here
  assign retire_s = (state_r == S_MEMWB)  || (state_r == S_RWB)  ||
                    (state_r == S_BRANCH) || (state_r == S_JUMP) ||
                    (state_r == S_ADDIWB) ||
                    ((state_r == S_MEMWR) && mem_ready);

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_r <= 32'd0;
    end else if (retire_s) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign instr_cnt = instr_cnt_r;
`else
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed vector table, randomized run
// against a queue-based instruction model, and an asynchronous reset sequence.
module tb_mc_main_ctrl;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] R_OP    = 6'b000000;
  localparam logic [5:0] LW_OP   = 6'b100011;
  localparam logic [5:0] SW_OP   = 6'b101011;
  localparam logic [5:0] BEQ_OP  = 6'b000100;
  localparam logic [5:0] J_OP    = 6'b000010;
  localparam logic [5:0] ADDI_OP = 6'b001000;
  localparam logic [5:0] BAD_OP  = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n, run, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_en, i_or_d, ir_write, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  mc_main_ctrl #(.OPW(6), .STW(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } strobes_t;

  strobes_t act_s;
  assign act_s = {pc_en, pc_src, i_or_d, ir_write, mem_read, mem_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  alu_op, illegal};

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op == R_OP) || (op == LW_OP) || (op == SW_OP) ||
           (op == BEQ_OP) || (op == J_OP) || (op == ADDI_OP);
  endfunction

  // Strobe table straight from the state descriptions
  function automatic strobes_t spec_out(input int st, input logic mr, input logic z,
                                        input logic [5:0] op);
    strobes_t s;
    s = '0;
    case (st)
      1:  begin s.mem_read = 1'b1; s.alu_src_b = 2'b01; s.ir_write = mr; s.pc_en = mr; end
      2:  begin s.alu_src_b = 2'b11; s.illegal = !is_legal(op); end
      3:  begin s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; end
      4:  begin s.mem_read = 1'b1; s.i_or_d = 1'b1; end
      5:  begin s.reg_write = 1'b1; s.mem_to_reg = 1'b1; end
      6:  begin s.mem_write = 1'b1; s.i_or_d = 1'b1; end
      7:  begin s.alu_src_a = 1'b1; s.alu_op = 2'b10; end
      8:  begin s.reg_write = 1'b1; s.reg_dst = 1'b1; end
      9:  begin s.alu_src_a = 1'b1; s.alu_op = 2'b01; s.pc_src = 2'b01; s.pc_en = z; end
      10: begin s.pc_src = 2'b10; s.pc_en = 1'b1; end
      11: begin s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; end
      12: begin s.reg_write = 1'b1; end
      default: s = '0;
    endcase
    return s;
  endfunction

  // Instruction-level model: remaining steps of the current instruction
  int          cur = 0;
  int          path[$];
  logic [31:0] cnt_m = 32'd0;

  task automatic route(input logic [5:0] op);
    path.delete();
    case (op)
      LW_OP:   path = '{3, 4, 5};
      SW_OP:   path = '{3, 6};
      R_OP:    path = '{7, 8};
      BEQ_OP:  path = '{9};
      J_OP:    path = '{10};
      ADDI_OP: path = '{11, 12};
      default: path.delete();
    endcase
  endtask

  task automatic model_step(input logic r, input logic mr, input logic [5:0] op);
    bit ret;
    ret = 1'b0;
    case (cur)
      0: cur = r ? 1 : 0;
      1: if (mr) cur = 2;
      2: begin
        route(op);
        if (path.size() == 0) cur = r ? 1 : 0;
        else cur = path.pop_front();
      end
      default: begin
        if ((cur != 4 && cur != 6) || mr) begin
          if (path.size() != 0) cur = path.pop_front();
          else begin ret = 1'b1; cur = r ? 1 : 0; end
        end
      end
    endcase
    if (ret) cnt_m = cnt_m + (PERF ? 32'd1 : 32'd0);
  endtask

  // One clock cycle: drive inputs at negedge, check, advance the model
  task automatic cycle(input logic r, input logic [5:0] op, input logic z,
                       input logic mr, input int exp_st, input string tag);
    @(negedge clk);
    run = r; opcode = op; zero = z; mem_ready = mr;
    #1;
    check({tag, " state"}, 32'(state), 32'(exp_st));
    check({tag, " strobes"}, 32'(act_s), 32'(spec_out(exp_st, mr, z, op)));
    check({tag, " instr_cnt"}, instr_cnt, cnt_m);
    model_step(r, mr, op);
  endtask

  typedef struct {
    logic       r;
    logic [5:0] op;
    logic       z;
    logic       mr;
    int         st;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] rop;

  initial begin
    // R-type, mem_ready=1
    tbl.push_back('{1'b1, R_OP, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, R_OP, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, R_OP, 1'b0, 1'b1, 2});
    tbl.push_back('{1'b1, R_OP, 1'b0, 1'b1, 7});
    tbl.push_back('{1'b1, R_OP, 1'b0, 1'b1, 8});
    // LW with three wait cycles in MEMRD
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b1, 2});
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b1, 3});
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b1, 4});
    tbl.push_back('{1'b1, LW_OP, 1'b0, 1'b1, 5});
    // BEQ taken, then not taken
    tbl.push_back('{1'b1, BEQ_OP, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, BEQ_OP, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, BEQ_OP, 1'b1, 1'b1, 9});
    tbl.push_back('{1'b1, BEQ_OP, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, BEQ_OP, 1'b0, 1'b1, 2});
    tbl.push_back('{1'b1, BEQ_OP, 1'b0, 1'b1, 9});
    // unsupported opcode
    tbl.push_back('{1'b1, BAD_OP, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, BAD_OP, 1'b0, 1'b1, 2});
    // R-type with run dropped during EXEC
    tbl.push_back('{1'b1, R_OP, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, R_OP, 1'b0, 1'b1, 2});
    tbl.push_back('{1'b0, R_OP, 1'b0, 1'b1, 7});
    tbl.push_back('{1'b0, R_OP, 1'b0, 1'b1, 8});
    tbl.push_back('{1'b0, R_OP, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b0, R_OP, 1'b0, 1'b1, 0});

    rst_n = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset strobes", 32'(act_s), 32'd0);
    check("reset instr_cnt", instr_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      cycle(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].st, $sformatf("vec%0d", i));

    // randomized traffic; opcode only changes before DECODE
    rop = R_OP;
    for (int n = 0; n < 600; n++) begin
      if (cur <= 1) begin
        case ($urandom_range(0, 7))
          0: rop = R_OP;
          1: rop = LW_OP;
          2: rop = SW_OP;
          3: rop = BEQ_OP;
          4: rop = J_OP;
          5: rop = ADDI_OP;
          default: rop = 6'($urandom_range(0, 63));
        endcase
      end
      cycle(($urandom_range(0, 9) != 0), rop, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), cur, $sformatf("rnd%0d", n));
    end

    // drain to IDLE, then reset in the middle of a stalled LW read
    for (int k = 0; k < 40 && cur != 0; k++) cycle(1'b0, rop, 1'b0, 1'b1, cur, "drain");
    cycle(1'b1, LW_OP, 1'b0, 1'b1, 0, "rstseq0");
    cycle(1'b1, LW_OP, 1'b0, 1'b1, 1, "rstseq1");
    cycle(1'b1, LW_OP, 1'b0, 1'b1, 2, "rstseq2");
    cycle(1'b1, LW_OP, 1'b0, 1'b1, 3, "rstseq3");
    cycle(1'b1, LW_OP, 1'b0, 1'b0, 4, "rstseq4");
    #1 rst_n = 1'b0;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset strobes", 32'(act_s), 32'd0);
    check("async reset instr_cnt", instr_cnt, 32'd0);
    run = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("fetch after reset", 32'(state), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle main control FSM that sequences the register-file/ALU/data-memory datapath.
- Drives every datapath control strobe per state: register-destination select, ALU B select, ALU op, memory read/write, mem-to-reg, register write, PC/IR enables.
- Sits between instruction register and datapath; decodes opcode, consumes ALU zero and a memory-ready handshake.

Parameters:
- OPW, 6, opcode width
- STW, 4, state register width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = keep fetching, 0 = park in IDLE after current instruction
- opcode  in  OPW  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory access complete this cycle
- pc_en  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut reg (branch), 10 jump target
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- ir_write  out  1  IR load enable
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- mem_to_reg  out  1  write-back select: 1 memory data
- reg_dst  out  1  write register: 0 rt, 1 rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  STW  current state, debug
- instr_cnt  out  32  retired-instruction count (optional feature)

Behaviour:
- Clock clk; reset asynchronous, active-low on rst_n. Reset: state=IDLE, every output 0, instr_cnt=0.
- Outputs are Moore-decoded from the state register, except pc_en/ir_write, which are qualified by mem_ready in FETCH. Undefined strobes are 0.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States and transitions:
  - IDLE(0): all outputs 0. Go to FETCH when run=1.
  - FETCH(1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Hold until mem_ready=1; in that cycle ir_write=1, pc_en=1, then go to DECODE.
  - DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode: LW/SW to MEMADR, R to EXEC, BEQ to BRANCH, J to JUMP, ADDI to ADDIEX. Any other opcode: illegal=1, then FETCH if run else IDLE.
  - MEMADR(3): alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD(4): mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB(5): reg_write=1, reg_dst=0, mem_to_reg=1. Retire.
  - MEMWR(6): mem_write=1, i_or_d=1. Hold until mem_ready, then retire.
  - EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
  - RWB(8): reg_write=1, reg_dst=1, mem_to_reg=0. Retire.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Retire.
  - JUMP(10): pc_src=10, pc_en=1. Retire.
  - ADDIEX(11): alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
  - ADDIWB(12): reg_write=1, reg_dst=0, mem_to_reg=0. Retire.
- Retire: next state is FETCH if run=1, else IDLE. run is sampled only in IDLE and on retire, so deasserting run mid-instruction never aborts it.
- mem_write/mem_read stay asserted continuously while waiting; there is no timeout.
- Unused state encodes (13-15) go to IDLE with all outputs 0.
- Latencies with mem_ready tied to 1: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4 cycles.

Optional Feature:
- CTRL_PERF_CNT_EN defined: instr_cnt increments by 1 on every retire cycle (illegal opcodes excluded) and wraps at 2^32. It is cleared only by rst_n.
- Undefined: instr_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package holds: opcode constants; state encodings; alu_op, alu_src_b and pc_src encodings.
- One natural sub-module: mc_out_decode, a purely combinational state-to-strobe decoder. The FSM next-state logic and counter stay in the top module.

Test Plan:
- Reset mid-MEMRD (drop rst_n): state=0, all outputs 0 immediately, without waiting for clk. Release rst_n with run=1: FETCH on the next edge.
- R-type, opcode 000000, mem_ready=1: states 1,2,7,8. reg_write=1 with reg_dst=1 in state 8 only; instr_cnt 0 to 1.
- LW, opcode 100011, mem_ready low 3 cycles in MEMRD: state 4 held 4 cycles with mem_read=1, i_or_d=1; then MEMWB with mem_to_reg=1.
- BEQ with zero=1, then BEQ with zero=0: pc_en=1 with pc_src=01 in state 9 for the first; pc_en=0 for the second.
- Opcode 111111: illegal pulses for 1 cycle in DECODE; next state FETCH; instr_cnt unchanged.
- run dropped during EXEC of an R-type: RWB completes with reg_write=1, then IDLE; no FETCH occurs.
